// File: rtl/ser_tx.sv
// UART-style frame transmitter: start bit, WIDTH data bits LSB-first, optional even parity, stop bit.
// Define SER_TX_PARITY_EN to insert the even-parity bit between the data and stop bits.
module ser_tx #(
    parameter int WIDTH = 8,
    parameter int DIV   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    output logic             tx,
    output logic             busy,
    output logic             done
);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(WIDTH - 1);

`ifdef SER_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t             state_reg, state_next;
    logic [WIDTH-1:0]   shift_reg, shift_next;
    logic [DIV_W-1:0]   div_reg, div_next;
    logic [CNT_W-1:0]   bit_reg, bit_next;
    logic               tx_reg, tx_next;
    logic               busy_reg, busy_next;
    logic               done_reg, done_next;
    logic               bit_end;
`ifdef SER_TX_PARITY_EN
    logic               parity_reg, parity_next;
`endif

    // Asynchronous clear so an aborted frame releases the line to idle at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            shift_reg  <= '0;
            div_reg    <= '0;
            bit_reg    <= '0;
            tx_reg     <= 1'b1;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
`ifdef SER_TX_PARITY_EN
            parity_reg <= 1'b0;
`endif
        end else begin
            state_reg  <= state_next;
            shift_reg  <= shift_next;
            div_reg    <= div_next;
            bit_reg    <= bit_next;
            tx_reg     <= tx_next;
            busy_reg   <= busy_next;
            done_reg   <= done_next;
`ifdef SER_TX_PARITY_EN
            parity_reg <= parity_next;
`endif
        end
    end

    always_comb begin
        state_next  = state_reg;
        shift_next  = shift_reg;
        div_next    = div_reg;
        bit_next    = bit_reg;
        done_next   = 1'b0;
`ifdef SER_TX_PARITY_EN
        parity_next = parity_reg;
`endif
        bit_end     = (div_reg == DIV_LAST);

        case (state_reg)
            IDLE: begin
                if (start) begin
                    shift_next  = data_in;
                    div_next    = '0;
                    bit_next    = '0;
                    state_next  = START;
`ifdef SER_TX_PARITY_EN
                    parity_next = ^data_in;
`endif
                end
            end
            START: begin
                if (bit_end) begin
                    div_next   = '0;
                    state_next = DATA;
                end else begin
                    div_next = div_reg + DIV_W'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    div_next = '0;
                    if (bit_reg == BIT_LAST) begin
`ifdef SER_TX_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end else begin
                        bit_next   = bit_reg + CNT_W'(1);
                        shift_next = shift_reg >> 1;
                    end
                end else begin
                    div_next = div_reg + DIV_W'(1);
                end
            end
`ifdef SER_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    div_next   = '0;
                    state_next = STOP;
                end else begin
                    div_next = div_reg + DIV_W'(1);
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    div_next   = '0;
                    state_next = IDLE;
                    done_next  = 1'b1;
                end else begin
                    div_next = div_reg + DIV_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase

        // Line level is derived from the state being entered so tx stays a pure register.
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_next[0];
`ifdef SER_TX_PARITY_EN
            PARITY:  tx_next = parity_next;
`endif
            default: tx_next = 1'b1;
        endcase
        busy_next = (state_next != IDLE);
    end

    assign tx   = tx_reg;
    assign busy = busy_reg;
    assign done = done_reg;
endmodule

// File: tb/tb_ser_tx.sv
// Scoreboard bench for ser_tx: stimulus queues expected words, a monitor rebuilds each frame from tx.
// Compile with SER_TX_PARITY_EN defined to exercise the parity build.
module tb_ser_tx;
    localparam int WIDTH = 8;
    localparam int DIV   = 4;
`ifdef SER_TX_PARITY_EN
    localparam int PBITS = 1;
`else
    localparam int PBITS = 0;
`endif
    localparam int NBITS = WIDTH + 2 + PBITS;
    localparam int F     = NBITS * DIV;
    localparam int LIMIT = 4 * F;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] data_in = '0;
    logic             tx, busy, done;

    ser_tx #(.WIDTH(WIDTH), .DIV(DIV)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .data_in(data_in),
        .tx(tx), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int               errors = 0;
    int               checks = 0;
    int               frame_no = 0;
    logic [WIDTH-1:0] exp_q[$];
    logic             samples[$];
    logic [WIDTH-1:0] mon_word;
    int               mon_bad;
    logic             mon_bit;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Monitor: gathers tx while busy, and on done compares against the reference frame.
    always @(negedge clk) begin
        if (!rst_n) begin
            samples.delete();
            exp_q.delete();
        end else begin
            check("busy_done_exclusive", {31'd0, busy & done}, 32'd0);
            if (busy) samples.push_back(tx);
            else      check("idle_tx_high", {31'd0, tx}, 32'd1);
            if (done) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL frame_unexpected: done with no frame queued");
                end else begin
                    mon_word = exp_q.pop_front();
                    mon_bad  = 0;
                    for (int b = 0; b < NBITS; b++) begin
                        if (b == 0)                          mon_bit = 1'b0;
                        else if (b <= WIDTH)                 mon_bit = mon_word[b-1];
                        else if (PBITS == 1 && b == WIDTH+1) mon_bit = ^mon_word;
                        else                                 mon_bit = 1'b1;
                        for (int d = 0; d < DIV; d++) begin
                            if (b*DIV + d >= samples.size() || samples[b*DIV + d] !== mon_bit)
                                mon_bad++;
                        end
                    end
                    check("frame_len", samples.size(), F);
                    check("frame_bits", mon_bad, 0);
                    $display("frame %0d data=%h samples=%0d bad_samples=%0d",
                             frame_no, mon_word, samples.size(), mon_bad);
                    frame_no++;
                end
                samples.delete();
            end
        end
    end

    task automatic accept(input logic [WIDTH-1:0] w);
        int t = 0;
        while (busy && t < LIMIT) begin
            @(negedge clk);
            t++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: busy stuck high, expected 0");
        end
        start   = 1'b1;
        data_in = w;
        exp_q.push_back(w);
        @(negedge clk);
        start   = 1'b0;
        data_in = WIDTH'($urandom);
        check("accept_tx", {31'd0, tx}, 32'd0);
        check("accept_busy", {31'd0, busy}, 32'd1);
    endtask

    task automatic wait_done(output int off);
        off = 0;
        while (!done && off < LIMIT) begin
            @(negedge clk);
            off++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: no done within %0d cycles", LIMIT);
        end
    endtask

    initial begin
        int off;
        repeat (3) @(negedge clk);
        check("reset_tx", {31'd0, tx}, 32'd1);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);

        accept(8'hA5);
        wait_done(off);
        check("done_time_a5", off, F);
        accept(8'h07);
        wait_done(off);
        check("done_time_07", off, F);

        // start re-pulsed with new data mid-frame must be ignored
        accept(8'hA5);
        off = 0;
        while (!done && off < LIMIT) begin
            @(negedge clk);
            off++;
            if (off == 10) begin
                start   = 1'b1;
                data_in = 8'h3C;
            end else begin
                start = 1'b0;
            end
        end
        check("done_time_repulse", off, F);
        repeat (3) @(negedge clk);
        check("no_restart_busy", {31'd0, busy}, 32'd0);

        // start held high: back-to-back frames with one idle cycle
        accept(8'hFF);
        start = 1'b1;
        wait_done(off);
        check("done_time_ff", off, F);
        data_in = 8'h00;
        exp_q.push_back(8'h00);
        @(negedge clk);
        start = 1'b0;
        check("b2b_busy", {31'd0, busy}, 32'd1);
        check("b2b_tx", {31'd0, tx}, 32'd0);
        wait_done(off);
        check("done_time_00", off, F);

        // asynchronous abort mid-frame
        accept(WIDTH'($urandom));
        repeat (15) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort_tx", {31'd0, tx}, 32'd1);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_abort_done", {31'd0, done}, 32'd0);
        check("post_abort_busy", {31'd0, busy}, 32'd0);
        accept(WIDTH'($urandom));
        wait_done(off);
        check("done_time_post_abort", off, F);

        for (int i = 0; i < 12; i++) begin
            accept(WIDTH'($urandom));
            wait_done(off);
            check("done_time_random", off, F);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
